ecdsa_sig_receiver: RTL and testbench
=====================================

// Module: ecdsa_sig_receiver
// PURPOSE
//  Receive end of the sign->verify path. Accepts an (r,s) signature streamed as WIDTH-bit words.
//  Reassembles r and s, range-checks them against n, then drives ECDSA_verify through its go/done handshake.
//  Returns a single pass/fail result. Sits between the signature link and ECDSA_verify.
// PARAMETERS
//  WIDTH         32  stream word width; KEY_SIZE must be a multiple of WIDTH
//  KEY_SIZE      64  width of r and s
//  INTEGER_SIZE  64  width of group order n (>= KEY_SIZE)
//  (localparam WORDS = KEY_SIZE/WIDTH; frame length = 2*WORDS words)
// PORTS
//  clk            in   1             clock, rising edge
//  rst            in   1             asynchronous, active-low reset
//  in_valid       in   1             stream word valid
//  in_data        in   WIDTH         stream word
//  in_last        in   1             marks final word of frame
//  in_ready       out  1             block accepts word this cycle
//  n              in   INTEGER_SIZE  group order, sampled in CHECK
//  verify_ready   in   1             ECDSA_verify idle
//  verify_go      out  1             start to ECDSA_verify
//  verify_done    in   1             ECDSA_verify finished
//  verified       in   1             ECDSA_verify result, valid with verify_done
//  r_out          out  KEY_SIZE      assembled r (to ECDSA_verify.r)
//  s_out          out  KEY_SIZE      assembled s (to ECDSA_verify.s)
//  result_valid   out  1             one-cycle result pulse
//  result_pass    out  1             1 = signature verified; valid with result_valid
//  err_range      out  1             one-cycle pulse: r or s out of [1,n-1]
//  err_framing    out  1             one-cycle pulse: in_last misplaced
//  busy           out  1             high in every state except RECV
// BEHAVIOUR
//  - Reset (rst=0) forces state RECV, word count 0, and clears r_out, s_out and every output to 0.
//    Exception: in_ready=1 in RECV once rst releases. Reset is honoured in any state; verify_go drops at once.
//  - Word accepted on a rising edge with in_valid & in_ready.
//    Order: r LS word first through r MS word, then s LS word first through s MS word.
//  - States:
//    RECV: in_ready=1. The counter (clog2(2*WORDS) bits) indexes the word.
//      in_last on index 2*WORDS-1 -> CHECK.
//      in_last on an earlier index -> err_framing pulse, counter 0, stay in RECV; the partial frame is discarded.
//      Index 2*WORDS-1 without in_last -> err_framing pulse, go to DRAIN.
//    DRAIN: in_ready=1. Words are discarded until one with in_last is accepted, then go to RECV with counter 0.
//    CHECK: 1 cycle, in_ready=0. r and s are zero-extended to INTEGER_SIZE.
//      r==0 | s==0 | r>=n | s>=n -> REPORT with pass=0 and err_range pulse; no verify is launched.
//      Otherwise -> WAIT_RDY.
//    WAIT_RDY: hold until verify_ready=1, then go to GO.
//    GO: verify_go=1, held high until verify_done is sampled 1.
//      Then verify_go=0, latch verified, go to REPORT.
//    REPORT: result_valid=1 for exactly one cycle and result_pass=latched value, then go to RECV.
//  - Latency: CHECK is the cycle after the last word. verify_go rises the cycle after CHECK if verify_ready is already 1.
//    result_valid is the cycle after verify_done is sampled.
//  - r_out and s_out are stable from CHECK until the next frame's first word is accepted.
//  - in_valid with in_ready=0 is ignored, not buffered; the sender holds the word.
//  - verify_done outside GO is ignored. verify_done and in_valid never interact, because in_ready=0 in GO.
//  - n is treated as unsigned. n<=1 makes every signature fail the range check.
// TESTING
//  1. n=7; words 3,0,5,0 with last on the 4th; stub verify returns verify_done with verified=1 after 10 cycles.
//     -> CHECK then verify_go; result_valid pulse with pass=1; r_out=3, s_out=5.
//  2. n=7; words 3,0,7,0 -> err_range pulse, result_valid with pass=0, verify_go never asserted.
//     Repeat with r=0 -> same response.
//  3. in_last on the 2nd word -> err_framing pulse, in_ready stays 1.
//     Then valid frame 1,0,2,0 -> accepted, r_out=1, s_out=2.
//  4. 4th word without in_last, then two more words, last on the 2nd of them -> err_framing on the 4th word.
//     Both extra words consumed in DRAIN; RECV follows.
//  5. verify_ready=0 for 5 cycles after CHECK -> verify_go stays 0, then rises the cycle after verify_ready=1.
//     Stub returns verified=0 -> pass=0.
//  6. rst=0 while in GO -> verify_go and busy go 0 without a clock edge.
//     After release: in_ready=1, r_out=s_out=0, no result_valid.

Source files
------------

// File: rtl/ecdsa_sig_receiver.sv
// Receive end of the sign->verify path: reassembles a streamed (r,s) signature,
// range-checks it against n and runs ECDSA_verify through its go/done handshake.
module ecdsa_sig_receiver #(
  parameter int WIDTH        = 32,
  parameter int KEY_SIZE     = 64,
  parameter int INTEGER_SIZE = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic [INTEGER_SIZE-1:0] n,
  input  logic                    verify_ready,
  output logic                    verify_go,
  input  logic                    verify_done,
  input  logic                    verified,
  output logic [KEY_SIZE-1:0]     r_out,
  output logic [KEY_SIZE-1:0]     s_out,
  output logic                    result_valid,
  output logic                    result_pass,
  output logic                    err_range,
  output logic                    err_framing,
  output logic                    busy
);

  localparam int WORDS = KEY_SIZE / WIDTH;
  localparam int FRAME = 2 * WORDS;
  localparam int CNT_W = $clog2(FRAME);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME - 1);

  typedef enum logic [2:0] {
    RECV,
    DRAIN,
    CHECK,
    WAIT_RDY,
    GO,
    REPORT
  } state_t;

  state_t                  state, state_next;
  logic [CNT_W-1:0]        cnt, cnt_next;
  logic [KEY_SIZE-1:0]     r_q, s_q;
  logic                    pass_q;
  logic                    framing_q, range_q;
  logic                    store_word, framing_set, range_set;
  logic [INTEGER_SIZE-1:0] r_ext, s_ext;
  logic                    range_bad;

  assign r_ext     = INTEGER_SIZE'(r_q);
  assign s_ext     = INTEGER_SIZE'(s_q);
  assign range_bad = (r_q == '0) || (s_q == '0) || (r_ext >= n) || (s_ext >= n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RECV;
      cnt       <= '0;
      r_q       <= '0;
      s_q       <= '0;
      pass_q    <= 1'b0;
      framing_q <= 1'b0;
      range_q   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      framing_q <= framing_set;
      range_q   <= range_set;
      if (state == CHECK)
        pass_q <= 1'b0;
      else if (state == GO && verify_done)
        pass_q <= verified;
      // Words land LS-first: indices 0..WORDS-1 fill r, the rest fill s.
      if (store_word) begin
        for (int i = 0; i < WORDS; i++) begin
          if (cnt == CNT_W'(i))         r_q[i*WIDTH +: WIDTH] <= in_data;
          if (cnt == CNT_W'(i + WORDS)) s_q[i*WIDTH +: WIDTH] <= in_data;
        end
      end
    end
  end

  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    store_word  = 1'b0;
    framing_set = 1'b0;
    range_set   = 1'b0;
    unique case (state)
      RECV: begin
        if (in_valid) begin
          store_word = 1'b1;
          if (cnt == LAST_IDX) begin
            cnt_next = '0;
            if (in_last) begin
              state_next = CHECK;
            end else begin
              framing_set = 1'b1;
              state_next  = DRAIN;
            end
          end else if (in_last) begin
            framing_set = 1'b1;
            cnt_next    = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      DRAIN: begin
        if (in_valid && in_last) state_next = RECV;
      end
      CHECK: begin
        if (range_bad) begin
          range_set  = 1'b1;
          state_next = REPORT;
        end else if (verify_ready) begin
          state_next = GO;
        end else begin
          state_next = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (verify_ready) state_next = GO;
      end
      GO: begin
        if (verify_done) state_next = REPORT;
      end
      REPORT: state_next = RECV;
      default: state_next = RECV;
    endcase
  end

  // Reset holds state in RECV, so only in_ready needs explicit gating by rst.
  assign in_ready     = rst && (state == RECV || state == DRAIN);
  assign verify_go    = (state == GO);
  assign result_valid = (state == REPORT);
  assign result_pass  = (state == REPORT) && pass_q;
  assign err_range    = range_q;
  assign err_framing  = framing_q;
  assign busy         = (state != RECV);
  assign r_out        = r_q;
  assign s_out        = s_q;

endmodule

// File: tb/tb_ecdsa_sig_receiver.sv
// Randomized self-checking bench for ecdsa_sig_receiver with a verify stub and
// a frame-level reference model of the range check and handshake timing.
module tb_ecdsa_sig_receiver;

  localparam int WIDTH        = 32;
  localparam int KEY_SIZE     = 64;
  localparam int INTEGER_SIZE = 64;
  localparam int WORDS        = KEY_SIZE / WIDTH;
  localparam int FRAME        = 2 * WORDS;

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic [WIDTH-1:0]        in_data;
  logic                    in_last;
  logic                    in_ready;
  logic [INTEGER_SIZE-1:0] n;
  logic                    verify_ready;
  logic                    verify_go;
  logic                    verify_done;
  logic                    verified;
  logic [KEY_SIZE-1:0]     r_out;
  logic [KEY_SIZE-1:0]     s_out;
  logic                    result_valid;
  logic                    result_pass;
  logic                    err_range;
  logic                    err_framing;
  logic                    busy;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] fw[$];
  logic             fl[$];

  ecdsa_sig_receiver #(
    .WIDTH(WIDTH), .KEY_SIZE(KEY_SIZE), .INTEGER_SIZE(INTEGER_SIZE)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .n(n), .verify_ready(verify_ready), .verify_go(verify_go),
    .verify_done(verify_done), .verified(verified), .r_out(r_out), .s_out(s_out),
    .result_valid(result_valid), .result_pass(result_pass), .err_range(err_range),
    .err_framing(err_framing), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference rule: both values must lie in [1, n-1] as unsigned integers.
  function automatic bit range_ok(input logic [KEY_SIZE-1:0] r, input logic [KEY_SIZE-1:0] s,
                                  input logic [INTEGER_SIZE-1:0] nn);
    return (r != 0) && (s != 0) && (INTEGER_SIZE'(r) < nn) && (INTEGER_SIZE'(s) < nn);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Drives the queued words from a negedge; returns at the negedge after the last accept.
  task automatic apply_stimulus(input int framing_idx);
    for (int j = 0; j < fw.size(); j++) begin
      in_valid = 1'b1;
      in_data  = fw[j];
      in_last  = fl[j];
      check_output("in_ready_word", in_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      check_output("err_framing", err_framing, (j == framing_idx));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic load_sig(input logic [KEY_SIZE-1:0] r, input logic [KEY_SIZE-1:0] s);
    fw.delete();
    fl.delete();
    for (int i = 0; i < WORDS; i++) begin
      fw.push_back(WIDTH'(r >> (i * WIDTH)));
      fl.push_back(1'b0);
    end
    for (int i = 0; i < WORDS; i++) begin
      fw.push_back(WIDTH'(s >> (i * WIDTH)));
      fl.push_back(i == WORDS - 1);
    end
  endtask

  task automatic good_frame(input logic [KEY_SIZE-1:0] r, input logic [KEY_SIZE-1:0] s,
                            input logic [INTEGER_SIZE-1:0] nn, input int rd, input int dd,
                            input logic v);
    bit ok;
    int exp_go, exp_res, go_seen, res_seen;
    ok       = range_ok(r, s, nn);
    exp_go   = ok ? ((rd <= 1) ? 2 : rd + 1) : -1;
    exp_res  = ok ? exp_go + dd + 1 : 2;
    go_seen  = -1;
    res_seen = -1;
    n            = nn;
    verify_ready = (rd == 0);
    verify_done  = 1'b0;
    load_sig(r, s);
    apply_stimulus(-1);
    check_output("check_busy", busy, 1'b1);
    check_output("check_in_ready", in_ready, 1'b0);
    for (int cyc = 1; cyc < 200; cyc++) begin
      if (verify_go && go_seen < 0) go_seen = cyc;
      if (result_valid) begin
        res_seen = cyc;
        check_output("result_pass", result_pass, ok && v);
        check_output("err_range", err_range, !ok);
        check_output("r_out", r_out, r);
        check_output("s_out", s_out, s);
        break;
      end
      if (go_seen >= 0 && cyc > go_seen && cyc <= go_seen + dd)
        check_output("go_held", verify_go, 1'b1);
      if (cyc >= rd) verify_ready = 1'b1;
      verify_done = (go_seen >= 0) && (cyc == go_seen + dd);
      verified    = verify_done ? v : 1'($urandom());
      @(negedge clk);
    end
    check_output("go_cycle", go_seen, exp_go);
    check_output("result_cycle", res_seen, exp_res);
    verify_done  = 1'b0;
    verify_ready = 1'($urandom());
    @(negedge clk);
    check_output("result_one_cycle", result_valid, 1'b0);
    check_output("idle_after_report", busy, 1'b0);
  endtask

  task automatic short_frame(input int k);
    fw.delete();
    fl.delete();
    for (int i = 0; i < k; i++) begin
      fw.push_back(WIDTH'($urandom()));
      fl.push_back(i == k - 1);
    end
    apply_stimulus(k - 1);
    check_output("short_idle", busy, 1'b0);
    check_output("short_ready", in_ready, 1'b1);
  endtask

  task automatic long_frame(input int m);
    fw.delete();
    fl.delete();
    for (int i = 0; i < FRAME + m; i++) begin
      fw.push_back(WIDTH'($urandom()));
      fl.push_back(i == FRAME + m - 1);
    end
    apply_stimulus(FRAME - 1);
    check_output("drain_exit_idle", busy, 1'b0);
  endtask

  task automatic reset_in_go();
    int rv_count;
    n            = 64'd7;
    verify_ready = 1'b1;
    verify_done  = 1'b0;
    load_sig(64'd3, 64'd5);
    apply_stimulus(-1);
    @(negedge clk);
    check_output("pre_reset_go", verify_go, 1'b1);
    #2 rst = 1'b0;
    #1;
    check_output("rst_go_async", verify_go, 1'b0);
    check_output("rst_busy_async", busy, 1'b0);
    check_output("rst_in_ready", in_ready, 1'b0);
    check_output("rst_r_out", r_out, 64'd0);
    check_output("rst_s_out", s_out, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_output("release_in_ready", in_ready, 1'b1);
    rv_count = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (result_valid) rv_count++;
    end
    check_output("no_result_after_reset", rv_count, 0);
  endtask

  initial begin
    logic [INTEGER_SIZE-1:0] nn;
    logic [KEY_SIZE-1:0]     r, s;
    int                      mode;
    rst          = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    in_last      = 1'b0;
    n            = '0;
    verify_ready = 1'b0;
    verify_done  = 1'b0;
    verified     = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_in_ready", in_ready, 1'b0);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_result_valid", result_valid, 1'b0);
    check_output("reset_verify_go", verify_go, 1'b0);
    check_output("reset_r_out", r_out, 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check_output("reset_release_ready", in_ready, 1'b1);

    good_frame(64'd3, 64'd5, 64'd7, 0, 10, 1'b1);
    good_frame(64'd3, 64'd7, 64'd7, 0, 2, 1'b1);
    good_frame(64'd0, 64'd5, 64'd7, 0, 2, 1'b1);
    short_frame(2);
    good_frame(64'd1, 64'd2, 64'd7, 0, 3, 1'b1);
    long_frame(2);
    good_frame(64'd3, 64'd5, 64'd7, 6, 4, 1'b0);
    good_frame(64'd6, 64'd6, 64'd7, 1, 0, 1'b1);
    good_frame(64'd1, 64'd1, 64'd1, 0, 0, 1'b1);
    good_frame(64'd1, 64'd1, 64'd0, 0, 0, 1'b1);
    good_frame(64'hFFFF_FFFF_FFFF_FFFE, 64'h1_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 2, 1, 1'b1);

    for (int t = 0; t < 30; t++) begin
      mode = int'($urandom_range(0, 6));
      nn   = rand64() | 64'd2;
      r    = 64'd1 + rand64() % (nn - 64'd1);
      s    = 64'd1 + rand64() % (nn - 64'd1);
      case (mode)
        0, 1, 2: ;
        3: r = '0;
        4: s = nn + rand64() % 64'd16;
        5: nn = 64'($urandom_range(0, 1));
        default: begin
          if ($urandom_range(0, 1) == 0) short_frame(int'($urandom_range(1, FRAME - 1)));
          else long_frame(int'($urandom_range(1, 3)));
        end
      endcase
      if (mode != 6)
        good_frame(r, s, nn, int'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
                   1'($urandom()));
    end

    reset_in_go();
    good_frame(64'd4, 64'd2, 64'd9, 0, 1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
